// File: rtl/branch_tgt_buf_pkg.sv
// Shared constants and entry layout for the direct-mapped branch target buffer.
package btb_pkg;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned TAG_W   = PC_W - IDX_W;
  localparam int unsigned CNT_W   = 16;

  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  localparam logic [1:0] CTR_MAX    = 2'b11;
  localparam logic [1:0] CTR_MIN    = 2'b00;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  tgt;
    logic [1:0]       ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_tgt_buf_if.sv
// Fetch lookup, EX-stage training and statistics bundle for the BTB.
interface branch_tgt_buf_if;
  import btb_pkg::*;

  logic [PC_W-1:0]  lkup_pc;
  logic             btb_hit;
  logic [PC_W-1:0]  btb_nxt_pc;
  logic             upd_en;
  logic [PC_W-1:0]  upd_pc;
  logic [PC_W-1:0]  upd_tgt;
  logic             upd_taken;
  logic             inv_all;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] alloc_cnt;

  modport master (
    output lkup_pc, upd_en, upd_pc, upd_tgt, upd_taken, inv_all,
    input  btb_hit, btb_nxt_pc, hit_cnt, alloc_cnt
  );

  modport slave (
    input  lkup_pc, upd_en, upd_pc, upd_tgt, upd_taken, inv_all,
    output btb_hit, btb_nxt_pc, hit_cnt, alloc_cnt
  );
endinterface

// File: rtl/branch_tgt_buf_sat_ctr2.sv
// 2-bit saturating up/down direction counter, next-state only.
module sat_ctr2
  import btb_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  output logic [1:0] o_ctr_c
);

  always_comb begin
    o_ctr_c = i_ctr;
    if (i_inc) begin
      if (i_ctr != CTR_MAX) o_ctr_c = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_MIN) o_ctr_c = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_tgt_buf.sv
// Direct-mapped BTB: same-cycle lookup from the flop array, one-cycle training
// from EX, plus saturating hit and allocation counters.
module branch_tgt_buf
  import btb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  branch_tgt_buf_if.slave  bus
);

  btb_entry_t       r_tbl [ENTRIES];
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_alloc_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  btb_entry_t       w_lk_e;
  btb_entry_t       w_up_e;
  logic             w_hit;
  logic             w_up_match;
  logic             w_alloc;
  logic [1:0]       w_ctr_nxt;

  assign w_lk_idx = bus.lkup_pc[IDX_W-1:0];
  assign w_lk_tag = bus.lkup_pc[PC_W-1:IDX_W];
  assign w_up_idx = bus.upd_pc[IDX_W-1:0];
  assign w_up_tag = bus.upd_pc[PC_W-1:IDX_W];
  assign w_lk_e   = r_tbl[w_lk_idx];
  assign w_up_e   = r_tbl[w_up_idx];

  // Lookup reads pre-update contents: no bypass from the training port.
  assign w_hit          = w_lk_e.valid && (w_lk_e.tag == w_lk_tag) && w_lk_e.ctr[1];
  assign bus.btb_hit    = w_hit;
  assign bus.btb_nxt_pc = w_hit ? w_lk_e.tgt : '0;

  assign w_up_match = w_up_e.valid && (w_up_e.tag == w_up_tag);
  assign w_alloc    = bus.upd_en && !bus.inv_all && !w_up_match && bus.upd_taken;

  sat_ctr2 u_sat_ctr2 (
    .i_ctr   (w_up_e.ctr),
    .i_inc   (bus.upd_taken),
    .o_ctr_c (w_ctr_nxt)
  );

  // Entry array; invalidate-all takes priority over training.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) r_tbl[i] <= '0;
    end else if (bus.inv_all) begin
      for (int i = 0; i < int'(ENTRIES); i++) r_tbl[i].valid <= 1'b0;
    end else if (bus.upd_en) begin
      if (w_up_match) begin
        r_tbl[w_up_idx].ctr <= w_ctr_nxt;
        if (bus.upd_taken) r_tbl[w_up_idx].tgt <= bus.upd_tgt;
      end else if (bus.upd_taken) begin
        r_tbl[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, tgt: bus.upd_tgt, ctr: CTR_WEAK_T};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt   <= '0;
      r_alloc_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != '1))     r_hit_cnt   <= r_hit_cnt + CNT_W'(1);
      if (w_alloc && (r_alloc_cnt != '1)) r_alloc_cnt <= r_alloc_cnt + CNT_W'(1);
    end
  end

  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.alloc_cnt = r_alloc_cnt;

endmodule

// File: tb/tb_branch_tgt_buf.sv
// Scoreboard bench for branch_tgt_buf: a behavioural model predicts each cycle's
// lookup result and counters, which are queued at drive time and checked mid-cycle.
module tb_branch_tgt_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_tgt_buf_if bif ();

  branch_tgt_buf u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic        hit;
    logic [15:0] nxt;
    int          hc;
    int          ac;
  } exp_t;

  exp_t sb [$];

  logic        m_v [16];
  logic [11:0] m_t [16];
  logic [15:0] m_g [16];
  int          m_c [16];
  int          m_hc;
  int          m_ac;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_t[i] = '0; m_g[i] = '0; m_c[i] = 0;
    end
    m_hc = 0;
    m_ac = 0;
  endtask

  function automatic logic model_hit(input logic [15:0] pc);
    int i;
    i = int'(pc[3:0]);
    return m_v[i] && (m_t[i] == pc[15:4]) && (m_c[i] >= 2);
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input string tag, input logic [15:0] lk, input logic en,
                      input logic [15:0] pc, input logic [15:0] tgt,
                      input logic tk, input logic inv);
    exp_t e, o;
    int i;
    bif.lkup_pc = lk; bif.upd_en = en; bif.upd_pc = pc;
    bif.upd_tgt = tgt; bif.upd_taken = tk; bif.inv_all = inv;
    e.hit = model_hit(lk);
    e.nxt = e.hit ? m_g[int'(lk[3:0])] : 16'h0000;
    e.hc  = m_hc;
    e.ac  = m_ac;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk({tag, ".hit"},   32'(bif.btb_hit),    32'(o.hit));
    chk({tag, ".nxt"},   32'(bif.btb_nxt_pc), 32'(o.nxt));
    chk({tag, ".hcnt"},  32'(bif.hit_cnt),    32'(o.hc));
    chk({tag, ".acnt"},  32'(bif.alloc_cnt),  32'(o.ac));
    @(posedge clk);
    if (o.hit && m_hc < 32'hFFFF) m_hc++;
    i = int'(pc[3:0]);
    if (inv) begin
      for (int k = 0; k < 16; k++) m_v[k] = 1'b0;
    end else if (en) begin
      if (m_v[i] && m_t[i] == pc[15:4]) begin
        if (tk) begin
          m_c[i] = (m_c[i] == 3) ? 3 : m_c[i] + 1;
          m_g[i] = tgt;
        end else begin
          m_c[i] = (m_c[i] == 0) ? 0 : m_c[i] - 1;
        end
      end else if (tk) begin
        m_v[i] = 1'b1; m_t[i] = pc[15:4]; m_g[i] = tgt; m_c[i] = 2;
        if (m_ac < 32'hFFFF) m_ac++;
      end
    end
    #1;
  endtask

  task automatic look(input string tag, input logic [15:0] lk);
    step(tag, lk, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input string tag, input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
    step(tag, 16'h0000, 1'b1, pc, tgt, tk, 1'b0);
  endtask

  initial begin
    bif.lkup_pc = 16'h0010; bif.upd_en = 1'b0; bif.upd_pc = '0;
    bif.upd_tgt = '0; bif.upd_taken = 1'b0; bif.inv_all = 1'b0;
    model_reset();
    #1;
    chk("rst_hit", 32'(bif.btb_hit), 32'h0);
    chk("rst_nxt", 32'(bif.btb_nxt_pc), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    look("rst_look", 16'h0010);
    chk("rst_hcnt", 32'(bif.hit_cnt), 32'h0);

    upd("alloc", 16'h0013, 16'h0040, 1'b1);
    look("alloc_look", 16'h0013);
    chk("alloc_hit_k", 32'(bif.btb_hit), 32'h1);
    chk("alloc_nxt_k", 32'(bif.btb_nxt_pc), 32'h0040);
    chk("alloc_cnt_k", 32'(bif.alloc_cnt), 32'h1);

    upd("nt1", 16'h0013, 16'h0000, 1'b0);
    upd("nt2", 16'h0013, 16'h0000, 1'b0);
    look("nt_look", 16'h0013);
    chk("nt_miss_k", 32'(bif.btb_hit), 32'h0);
    upd("tk1", 16'h0013, 16'h0040, 1'b1);
    look("tk1_look", 16'h0013);
    upd("tk2", 16'h0013, 16'h0040, 1'b1);
    look("tk2_look", 16'h0013);
    chk("tk_hit_k", 32'(bif.btb_hit), 32'h1);

    upd("alias", 16'h0023, 16'h0077, 1'b1);
    look("alias_old", 16'h0013);
    chk("alias_old_k", 32'(bif.btb_hit), 32'h0);
    look("alias_new", 16'h0023);
    chk("alias_nxt_k", 32'(bif.btb_nxt_pc), 32'h0077);
    chk("alias_acnt_k", 32'(bif.alloc_cnt), 32'h2);

    step("inv_upd", 16'h0023, 1'b1, 16'h0005, 16'h0099, 1'b1, 1'b1);
    look("inv_a", 16'h0023);
    look("inv_b", 16'h0005);
    chk("inv_acnt_k", 32'(bif.alloc_cnt), 32'h2);

    step("same_cyc", 16'h0013, 1'b1, 16'h0013, 16'h0040, 1'b1, 1'b0);
    look("same_nxt", 16'h0013);
    chk("same_hit_k", 32'(bif.btb_hit), 32'h1);

    for (int n = 0; n < 300; n++) begin
      logic [15:0] lk, pc;
      lk = {12'(($urandom_range(0, 2)) << 4 >> 4), 4'($urandom_range(0, 3))};
      pc = {12'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
      lk = {12'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
      step("rnd", lk, 1'($urandom_range(0, 1)), pc, 16'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    end

    upd("pre_rst", 16'h0013, 16'h0040, 1'b1);
    upd("pre_rst2", 16'h0013, 16'h0040, 1'b1);
    bif.lkup_pc = 16'h0013;
    bif.upd_en  = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_hcnt", 32'(bif.hit_cnt), 32'h0);
    chk("mid_rst_acnt", 32'(bif.alloc_cnt), 32'h0);
    chk("mid_rst_hit", 32'(bif.btb_hit), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    look("post_rst", 16'h0013);
    upd("post_alloc", 16'h0013, 16'h0040, 1'b1);
    look("post_look", 16'h0013);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
